// File: rtl/sm_divider.sv
// Sign-magnitude 15-bit / 7-bit restoring divider, one quotient bit per cycle.
// Valid/ready on both sides; results hold in DONE until the consumer takes them.
module sm_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [14:0] dvd;
    logic [14:0] quo;
    logic [6:0]  dsr;
    logic [6:0]  rem;
    logic        q_sign;
    logic        r_sign;

    logic        accept;
    logic        zero_div;
    logic        last_step;
    logic [7:0]  trial;
    logic [7:0]  diff;
    logic        q_bit;
    logic [6:0]  rem_nxt;
    logic [14:0] quo_nxt;

    assign accept    = (state == IDLE) && in_valid;
    assign zero_div  = (divisor[6:0] == 7'd0);
    assign last_step = (state == CALC) && (cnt == 4'd14);

    // Partial remainder always stays below the divisor, so 7 bits plus
    // the incoming dividend bit is enough for the trial value.
    always_comb begin
        trial   = {rem, dvd[14]};
        diff    = trial - {1'b0, dsr};
        q_bit   = (trial >= {1'b0, dsr});
        rem_nxt = q_bit ? diff[6:0] : trial[6:0];
        quo_nxt = {quo[13:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = zero_div ? DONE : CALC;
            end
            CALC: begin
                if (cnt == 4'd14)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 4'd0;
            dvd         <= 15'd0;
            quo         <= 15'd0;
            dsr         <= 7'd0;
            rem         <= 7'd0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            quotient    <= 16'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= 4'd0;
            dvd    <= dividend[14:0];
            dsr    <= divisor[6:0];
            rem    <= 7'd0;
            quo    <= 15'd0;
            q_sign <= dividend[15] ^ divisor[7];
            r_sign <= dividend[15];
            if (zero_div) begin
                quotient    <= 16'h7FFF;
                remainder   <= 8'h00;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            cnt <= last_step ? 4'd0 : cnt + 4'd1;
            dvd <= {dvd[13:0], 1'b0};
            rem <= rem_nxt;
            quo <= quo_nxt;
            // Zero magnitudes never carry a sign.
            if (last_step) begin
                quotient  <= {q_sign & (|quo_nxt), quo_nxt};
                remainder <= {r_sign & (|rem_nxt), rem_nxt};
            end
        end
    end

endmodule

// File: doc/sm_divider.md
SM_DIVIDER -- requirements
Module: sm_divider

Interface
REQ-001 No parameters; all widths are fixed to match the team's 8x8 sign-magnitude multiplier output format.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  dividend/divisor present.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 dividend  input  16  sign-magnitude: bit15 sign, [14:0] magnitude.
REQ-007 divisor  input  8  sign-magnitude: bit7 sign, [6:0] magnitude.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 quotient  output  16  sign-magnitude: bit15 sign, [14:0] magnitude.
REQ-011 remainder  output  8  sign-magnitude: bit7 sign, [6:0] magnitude.
REQ-012 div_by_zero  output  1  divisor magnitude was zero; valid with out_valid.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; when in_valid=1, operands are captured into internal registers and the FSM moves to CALC, or to DONE if divisor[6:0]==0.
REQ-015 In CALC, in_ready SHALL be 0, and each cycle SHALL perform one restoring step, MSB first over dividend[14:0]: r = {rem[6:0], next dividend bit}; if r >= divisor mag then rem = r - divisor mag and the quotient bit is 1, else rem = r and the quotient bit is 0.
REQ-016 A 4-bit step counter SHALL run 0..14; after the step at count 14, the FSM SHALL enter DONE (exactly 15 CALC cycles).
REQ-017 Latency: out_valid SHALL rise 16 cycles after the accept edge for a nonzero divisor, and 1 cycle after for a zero divisor.
REQ-018 Quotient sign SHALL be dividend[15] XOR divisor[7]; remainder sign SHALL be dividend[15].
REQ-019 Negative zero SHALL be normalized: a sign bit is forced to 0 when its magnitude is 0.
REQ-020 Divide by zero (divisor[6:0]==0, either sign) SHALL produce quotient=0x7FFF, remainder=0x00, div_by_zero=1.
REQ-021 DONE: out_valid=1 and in_ready=0; quotient, remainder and div_by_zero SHALL hold stable until out_ready=1.
REQ-022 On the cycle where out_valid=1 and out_ready=1, the FSM SHALL return to IDLE; there is no pipelining, and a new accept occurs no earlier than the following cycle.
REQ-023 in_valid SHALL be ignored outside IDLE; operand inputs are sampled only on the accept edge, and later input changes SHALL NOT affect the result.
REQ-024 Magnitude results SHALL be exact integer division: dividend_mag = q_mag*divisor_mag + r_mag, with r_mag < divisor_mag; no overflow is possible.

Reset
REQ-025 When rst=1 at a rising edge, the FSM SHALL go to IDLE and the counter, quotient, remainder, div_by_zero and out_valid SHALL all be 0, with in_ready=1 on the next cycle.
REQ-026 Reset SHALL take priority over every other event, including mid-CALC and during DONE with out_ready=1; any in-flight result SHALL be discarded.
REQ-027 in_valid asserted in the same cycle as rst SHALL NOT be accepted.

Verification
REQ-028 dividend=0x0064, divisor=0x07 -> quotient=0x000E, remainder=0x02, div_by_zero=0, out_valid high exactly 16 cycles after accept.
REQ-029 0x8064/0x07 -> 0x800E rem 0x82; 0x0064/0x87 -> 0x800E rem 0x02; 0x8064/0x87 -> 0x000E rem 0x82.
REQ-030 0x7FFF/0x01 -> 0x7FFF rem 0x00; 0x8003/0x05 -> 0x0000 rem 0x83 (quotient sign normalized); 0x0000/0x85 -> 0x0000 rem 0x00.
REQ-031 divisor=0x80 or 0x00 -> div_by_zero=1, quotient=0x7FFF, remainder=0x00, out_valid one cycle after accept.
REQ-032 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stay stable, in_ready=0, no accept; release out_ready -> IDLE, next operand pair accepted the following cycle.
REQ-033 Assert rst at CALC step 7 -> next cycle: in_ready=1, out_valid=0, all outputs 0; a fresh 0x0064/0x07 then completes correctly in 16 cycles.
